mux_scheduler: RTL and testbench

MUX_SCHEDULER -- requirements
Module: mux_scheduler

---
 rtl/mux_sched_pkg.sv | 19 +
 rtl/mux_sched_counter.sv | 52 +++++
 rtl/mux_scheduler.sv | 121 ++++++++++++
 tb/tb_mux_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared types for the serial-to-lane mux scheduler: FSM state, lane index and one-hot decode.
package mux_sched_pkg;

    localparam int unsigned LaneCount = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef logic [1:0] lane_t;

    function automatic logic [LaneCount-1:0] lane_onehot(input lane_t lane);
        lane_onehot       = '0;
        lane_onehot[lane] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_sched_counter.sv
// Slot, lane and bit counters for mux_scheduler; flags report the terminal accept of a slot/frame.
module mux_sched_counter
    import mux_sched_pkg::*;
#(
    parameter int unsigned BITS_PER_SLOT = 1,
    parameter int unsigned FRAME_BITS    = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_advance,
    output lane_t      o_lane,
    output logic [7:0] o_bit_count,
    output logic       o_frame_last
);

    localparam logic [2:0] SlotLast  = 3'(BITS_PER_SLOT - 1);
    localparam logic [7:0] FrameLast = 8'(FRAME_BITS - 1);

    logic [2:0] r_slot;
    lane_t      r_lane;
    logic [7:0] r_bit;
    logic       w_slot_last;

    assign w_slot_last = (r_slot == SlotLast);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot <= '0;
            r_lane <= '0;
            r_bit  <= '0;
        end else if (i_clear) begin
            r_slot <= '0;
            r_lane <= '0;
            r_bit  <= '0;
        end else if (i_advance) begin
            r_bit <= r_bit + 8'd1;
            if (w_slot_last) begin
                r_slot <= '0;
                r_lane <= r_lane + 2'd1;
            end else begin
                r_slot <= r_slot + 3'd1;
            end
        end
    end

    assign o_lane       = r_lane;
    assign o_bit_count  = r_bit;
    // High while the next accept is the one that completes the frame.
    assign o_frame_last = (r_bit == FrameLast);

endmodule

// File: rtl/mux_scheduler.sv
// Distributes a serial bit stream over four lanes in frames of FRAME_BITS accepted bits.
// Optional abort input is enabled by defining MUX_SCHEDULER_ABORT_EN.
module mux_scheduler
    import mux_sched_pkg::*;
#(
    parameter int unsigned BITS_PER_SLOT = 1,
    parameter int unsigned FRAME_BITS    = 32
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inStart,
    input  logic       inValid,
    input  logic       inData,
`ifdef MUX_SCHEDULER_ABORT_EN
    input  logic       inAbort,
`endif
    output logic [1:0] outSel,
    output logic       outData,
    output logic [3:0] outLaneEn,
    output logic       outBusy,
    output logic       outDone,
    output logic [7:0] outBitCount
);

    state_e     r_state;
    state_e     w_state_next;
    logic       w_accept;
    logic       w_clear;
    logic       w_abort;
    lane_t      w_lane;
    logic [7:0] w_bit_count;
    logic       w_frame_last;

    lane_t      r_sel;
    logic       r_data;
    logic [3:0] r_lane_en;
    logic       r_done;

`ifdef MUX_SCHEDULER_ABORT_EN
    assign w_abort = inAbort;
`else
    assign w_abort = 1'b0;
`endif

    mux_sched_counter #(
        .BITS_PER_SLOT (BITS_PER_SLOT),
        .FRAME_BITS    (FRAME_BITS)
    ) u_counter (
        .i_clk        (inClock),
        .i_rst_n      (inReset),
        .i_clear      (w_clear),
        .i_advance    (w_accept),
        .o_lane       (w_lane),
        .o_bit_count  (w_bit_count),
        .o_frame_last (w_frame_last)
    );

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            StIdle: begin
                // A bit presented alongside the start request is not accepted.
                if (inStart) begin
                    w_state_next = StRun;
                    w_clear      = 1'b1;
                end
            end
            StRun: begin
                if (w_abort) begin
                    w_state_next = StIdle;
                end else if (inValid) begin
                    w_accept = 1'b1;
                    if (w_frame_last) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Output stage: every lane-facing signal lags its accept by exactly one cycle.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            r_sel     <= '0;
            r_data    <= 1'b0;
            r_lane_en <= '0;
            r_done    <= 1'b0;
        end else begin
            r_lane_en <= w_accept ? lane_onehot(w_lane) : 4'b0000;
            r_done    <= (r_state == StDone);
            if (w_accept) begin
                r_sel  <= w_lane;
                r_data <= inData;
            end
        end
    end

    assign outSel      = r_sel;
    assign outData     = r_data;
    assign outLaneEn   = r_lane_en;
    assign outDone     = r_done;
    assign outBusy     = (r_state == StRun);
    assign outBitCount = w_bit_count;

endmodule

// File: tb/tb_mux_scheduler.sv
// Scoreboard bench for mux_scheduler: two instances (1 bit/slot x 32, 2 bits/slot x 8) share stimulus.
module tb_mux_scheduler;

    typedef struct packed {
        logic       done;
        logic [1:0] sel;
        logic       data;
        logic [3:0] en;
        logic [7:0] cnt;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_start = 1'b0;
    logic in_valid = 1'b0;
    logic in_data = 1'b0;
    logic in_abort = 1'b0;

    logic [1:0] d1_sel, d2_sel;
    logic       d1_data, d2_data, d1_busy, d2_busy, d1_done, d2_done;
    logic [3:0] d1_en, d2_en;
    logic [7:0] d1_cnt, d2_cnt;

    int checks = 0;
    int errors = 0;

    item_t q1[$];
    item_t q2[$];

    int       m_state[2];
    int       m_count[2];
    int       m_bps[2];
    int       m_frame[2];
    logic [1:0] m_sel[2];
    logic     m_data[2];

    always #5 clk = ~clk;

    mux_scheduler #(.BITS_PER_SLOT(1), .FRAME_BITS(32)) dut1 (
        .inClock     (clk),
        .inReset     (rst_n),
        .inStart     (in_start),
        .inValid     (in_valid),
        .inData      (in_data),
`ifdef MUX_SCHEDULER_ABORT_EN
        .inAbort     (in_abort),
`endif
        .outSel      (d1_sel),
        .outData     (d1_data),
        .outLaneEn   (d1_en),
        .outBusy     (d1_busy),
        .outDone     (d1_done),
        .outBitCount (d1_cnt)
    );

    mux_scheduler #(.BITS_PER_SLOT(2), .FRAME_BITS(8)) dut2 (
        .inClock     (clk),
        .inReset     (rst_n),
        .inStart     (in_start),
        .inValid     (in_valid),
        .inData      (in_data),
`ifdef MUX_SCHEDULER_ABORT_EN
        .inAbort     (in_abort),
`endif
        .outSel      (d2_sel),
        .outData     (d2_data),
        .outLaneEn   (d2_en),
        .outBusy     (d2_busy),
        .outDone     (d2_done),
        .outBitCount (d2_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input item_t it);
        if (k == 0) q1.push_back(it);
        else        q2.push_back(it);
    endtask

    // Transaction-level model of one instance, advanced once per clock edge.
    task automatic model_step(input int k, input logic s, input logic v, input logic d,
                              input logic a);
        item_t it;
        int    lane;
        case (m_state[k])
            0: if (s) begin
                m_state[k] = 1;
                m_count[k] = 0;
            end
            1: begin
                if (a) begin
                    m_state[k] = 0;
                end else if (v) begin
                    lane       = (m_count[k] / m_bps[k]) % 4;
                    m_count[k] = m_count[k] + 1;
                    m_sel[k]   = 2'(lane);
                    m_data[k]  = d;
                    it.done = 1'b0;
                    it.sel  = m_sel[k];
                    it.data = d;
                    it.en   = 4'b0001 << lane;
                    it.cnt  = 8'(m_count[k]);
                    push(k, it);
                    if (m_count[k] == m_frame[k]) begin
                        it.done = 1'b1;
                        it.en   = 4'b0000;
                        push(k, it);
                        m_state[k] = 2;
                    end
                end
            end
            default: m_state[k] = 0;
        endcase
    endtask

    task automatic cycle(input logic s, input logic v, input logic d, input logic a);
        in_start = s;
        in_valid = v;
        in_data  = d;
        in_abort = a;
        model_step(0, s, v, d, a);
        model_step(1, s, v, d, a);
        @(posedge clk);
        #1;
        in_start = 1'b0;
        in_valid = 1'b0;
        in_abort = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_count[k] = 0;
            m_sel[k]   = 2'd0;
            m_data[k]  = 1'b0;
        end
    endtask

    task automatic check_drained(input string name);
        check({name, " dut1 pending"}, q1.size(), 0);
        check({name, " dut2 pending"}, q2.size(), 0);
    endtask

    always @(negedge clk) begin
        item_t exp;
        if (rst_n && (d1_en != 4'b0000 || d1_done)) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1 unexpected output: en=%b done=%b cnt=%0d, expected none",
                         d1_en, d1_done, d1_cnt);
            end else begin
                exp = q1.pop_front();
                if ({d1_done, d1_sel, d1_data, d1_en, d1_cnt} !== exp) begin
                    errors++;
                    $display("FAIL dut1 output: got done=%b sel=%0d data=%b en=%b cnt=%0d, expected done=%b sel=%0d data=%b en=%b cnt=%0d",
                             d1_done, d1_sel, d1_data, d1_en, d1_cnt,
                             exp.done, exp.sel, exp.data, exp.en, exp.cnt);
                end
            end
        end
    end

    always @(negedge clk) begin
        item_t exp;
        if (rst_n && (d2_en != 4'b0000 || d2_done)) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL dut2 unexpected output: en=%b done=%b cnt=%0d, expected none",
                         d2_en, d2_done, d2_cnt);
            end else begin
                exp = q2.pop_front();
                if ({d2_done, d2_sel, d2_data, d2_en, d2_cnt} !== exp) begin
                    errors++;
                    $display("FAIL dut2 output: got done=%b sel=%0d data=%b en=%b cnt=%0d, expected done=%b sel=%0d data=%b en=%b cnt=%0d",
                             d2_done, d2_sel, d2_data, d2_en, d2_cnt,
                             exp.done, exp.sel, exp.data, exp.en, exp.cnt);
                end
            end
        end
    end

    initial begin
        logic [31:0] pat;
        pat = 32'hA5A5_A5A5;
        m_bps   = '{1, 2};
        m_frame = '{32, 8};
        model_reset();

        // Reset state, asynchronous.
        #1;
        check("reset dut1 outputs", {d1_sel, d1_data, d1_en, d1_busy, d1_done, d1_cnt}, 0);
        check("reset dut2 outputs", {d2_sel, d2_data, d2_en, d2_busy, d2_done, d2_cnt}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(0, 0, 0, 0);

        // Full frame of 0xA5A5A5A5, MSB first.
        cycle(1, 0, 0, 0);
        check("busy after start dut1", d1_busy, 1);
        check("busy after start dut2", d2_busy, 1);
        check("count cleared on start", d1_cnt, 0);
        for (int i = 0; i < 32; i++) cycle(0, 1, pat[31-i], 0);
        repeat (3) cycle(0, 0, 0, 0);
        check("frame A idle dut1 busy", d1_busy, 0);
        check("frame A held count dut1", d1_cnt, 32);
        check("frame A held count dut2", d2_cnt, 8);
        check_drained("frame A");

        // Start with valid (bit dropped), alternating valid, stray start at accept 10.
        cycle(1, 1, 1, 0);
        for (int i = 0; i < 64; i++) begin
            cycle((i == 20) ? 1'b1 : 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, pat[i % 32] ^ 1'b1, 0);
            if (i == 7) begin
                check("gap lane enable dut1", d1_en, 0);
                check("gap frozen count dut1", d1_cnt, 4);
            end
        end
        repeat (4) cycle(0, 0, 0, 0);
        check("frame B no restart dut1", d1_busy, 0);
        check("frame B held count dut1", d1_cnt, 32);
        check("frame B second frame dut2", d2_cnt, 8);
        check_drained("frame B");

        // Reset mid-frame after 17 accepts.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 17; i++) cycle(0, 1, pat[i], 0);
        cycle(0, 0, 0, 0);
        check_drained("pre-reset");
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid-frame reset dut1", {d1_sel, d1_data, d1_en, d1_busy, d1_done, d1_cnt}, 0);
        check("mid-frame reset dut2", {d2_sel, d2_data, d2_en, d2_busy, d2_done, d2_cnt}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) cycle(0, 0, 0, 0);
        check("no done after reset", d1_done, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, pat[i+4], 0);
        repeat (2) cycle(0, 0, 0, 0);
        check("restart count dut1", d1_cnt, 3);
        check("restart lane dut1", d1_sel, 2);
        check_drained("restart");
        // Finish the partial frame so both instances are idle again.
        for (int i = 0; i < 29; i++) cycle(0, 1, pat[i], 0);
        repeat (3) cycle(0, 0, 0, 0);
        check_drained("restart end");

`ifdef MUX_SCHEDULER_ABORT_EN
        // Abort together with valid after 5 accepts.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, pat[i], 0);
        cycle(0, 1, 1, 1);
        check("abort idle dut1", d1_busy, 0);
        check("abort count dut1", d1_cnt, 5);
        check("abort count dut2", d2_cnt, 5);
        repeat (3) cycle(0, 1, 1, 0);
        check("abort no done", d1_done, 0);
        check_drained("abort");
`endif

        repeat (2) cycle(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
